// File: rtl/pool_ctrl.sv
// pool_ctrl: walks an IMG_H x IMG_W feature map in non-overlapping KxK
// windows, gathers each window from the input BRAM into win_data, and
// writes the external max-pool result to the output BRAM.
module pool_ctrl #(
  parameter int DEPTH = 8,
  parameter int IMG_W = 4,
  parameter int IMG_H = 4,
  parameter int K     = 2,
  localparam int OUT_W = IMG_W / K,
  localparam int OUT_H = IMG_H / K,
  localparam int RA_W  = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
  localparam int WA_W  = (OUT_W * OUT_H > 1) ? $clog2(OUT_W * OUT_H) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_rd_en,
  output logic [RA_W-1:0]        o_rd_addr,
  input  logic [DEPTH-1:0]       i_rd_data,
  output logic [DEPTH*K*K-1:0]   o_win_data,
  input  logic [DEPTH-1:0]       i_pool_max,
  output logic                   o_wr_en,
  output logic [WA_W-1:0]        o_wr_addr,
  output logic [DEPTH-1:0]       o_wr_data
);

  localparam int EW = (K * K > 1) ? $clog2(K * K) : 1;
  localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [EW-1:0]          r_e;
  logic [RW-1:0]          r_wr;
  logic [CW-1:0]          r_wc;
  logic                   r_cap_vld;
  logic [EW-1:0]          r_cap_idx;
  logic [DEPTH*K*K-1:0]   r_win;

  logic                   w_e_last;
  logic                   w_col_last;
  logic                   w_row_last;
  logic [RA_W-1:0]        w_rd_addr_calc;
  logic [WA_W-1:0]        w_wr_addr_calc;
  logic                   w_busy;
  logic                   w_done;
  logic                   w_rd_en;
  logic [RA_W-1:0]        w_rd_addr;
  logic                   w_wr_en;
  logic [WA_W-1:0]        w_wr_addr;
  logic [DEPTH-1:0]       w_wr_data;

  assign w_e_last   = (r_e  == EW'(K * K - 1));
  assign w_col_last = (r_wc == CW'(OUT_W - 1));
  assign w_row_last = (r_wr == RW'(OUT_H - 1));

  // Pixel address of element e of window (wr,wc): row wr*K+e/K, column wc*K+e%K.
  assign w_rd_addr_calc = (RA_W'(r_wr) * RA_W'(K) + RA_W'(r_e) / RA_W'(K)) * RA_W'(IMG_W)
                        + RA_W'(r_wc) * RA_W'(K) + RA_W'(r_e) % RA_W'(K);
  assign w_wr_addr_calc = WA_W'(r_wr) * WA_W'(OUT_W) + WA_W'(r_wc);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_FETCH;
        else         w_next = S_IDLE;
      end
      S_FETCH: begin
        if (w_e_last) w_next = S_DRAIN;
        else          w_next = S_FETCH;
      end
      S_DRAIN: w_next = S_WRITE;
      S_WRITE: begin
        if (w_col_last && w_row_last) w_next = S_DONE;
        else                          w_next = S_FETCH;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from the current state and counters.
  always_comb begin
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_wr_data = '0;
    case (r_state)
      S_FETCH: begin
        w_busy    = 1'b1;
        w_rd_en   = 1'b1;
        w_rd_addr = w_rd_addr_calc;
      end
      S_DRAIN: w_busy = 1'b1;
      S_WRITE: begin
        w_busy    = 1'b1;
        w_wr_en   = 1'b1;
        w_wr_addr = w_wr_addr_calc;
        w_wr_data = i_pool_max;
      end
      S_DONE:  w_done = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Element and window counters: cleared on start, e steps in FETCH, (wr,wc) advance in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e  <= '0;
      r_wr <= '0;
      r_wc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_e  <= '0;
            r_wr <= '0;
            r_wc <= '0;
          end
        end
        S_FETCH: r_e <= w_e_last ? '0 : r_e + EW'(1);
        S_WRITE: begin
          if (w_col_last) begin
            r_wc <= '0;
            r_wr <= w_row_last ? '0 : r_wr + RW'(1);
          end else begin
            r_wc <= r_wc + CW'(1);
          end
        end
        default: r_e <= r_e;
      endcase
    end
  end

  // Read data lags rd_en by one cycle, so remember which element each read targets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
    end else begin
      r_cap_vld <= (r_state == S_FETCH);
      r_cap_idx <= r_e;
    end
  end

  // Window register: load the returning pixel into its element slot, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0;
    end else if (r_cap_vld) begin
      for (int n = 0; n < K * K; n++) begin
        if (r_cap_idx == EW'(n)) r_win[n*DEPTH +: DEPTH] <= i_rd_data;
      end
    end
  end

  assign o_busy     = w_busy;
  assign o_done     = w_done;
  assign o_rd_en    = w_rd_en;
  assign o_rd_addr  = w_rd_addr;
  assign o_wr_en    = w_wr_en;
  assign o_wr_addr  = w_wr_addr;
  assign o_wr_data  = w_wr_data;
  assign o_win_data = r_win;

endmodule

// File: tb/tb_pool_ctrl.sv
// Scoreboard bench for pool_ctrl: a 4x4 instance and an 8x4 instance.
module tb_pool_ctrl;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  data;
    bit          chk_win;
    logic [31:0] win;
  } exp_t;

  localparam int RSEQ [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start1, start2;
  logic busy1, done1, rd_en1, wr_en1;
  logic [3:0] rd_addr1;
  logic [1:0] wr_addr1;
  logic [7:0] rd_data1, pmax1, wr_data1;
  logic [31:0] win1;
  logic busy2, done2, rd_en2, wr_en2;
  logic [4:0] rd_addr2;
  logic [2:0] wr_addr2;
  logic [7:0] rd_data2, pmax2, wr_data2;
  logic [31:0] win2;

  logic [7:0] mem1 [16];
  logic [7:0] mem2 [32];

  exp_t sb1 [$];
  exp_t sb2 [$];
  int   rdq1 [$];
  exp_t x1, x2;
  int   a1;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt1 = 0;
  int   done_cnt2 = 0;
  int   lat;
  int   d0;

  pool_ctrl #(.DEPTH(8), .IMG_W(4), .IMG_H(4), .K(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .o_busy(busy1), .o_done(done1),
    .o_rd_en(rd_en1), .o_rd_addr(rd_addr1), .i_rd_data(rd_data1), .o_win_data(win1),
    .i_pool_max(pmax1), .o_wr_en(wr_en1), .o_wr_addr(wr_addr1), .o_wr_data(wr_data1));

  pool_ctrl #(.DEPTH(8), .IMG_W(8), .IMG_H(4), .K(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(start2), .o_busy(busy2), .o_done(done2),
    .o_rd_en(rd_en2), .o_rd_addr(rd_addr2), .i_rd_data(rd_data2), .o_win_data(win2),
    .i_pool_max(pmax2), .o_wr_en(wr_en2), .o_wr_addr(wr_addr2), .o_wr_data(wr_data2));

  // Input BRAMs: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= mem1[rd_addr1];
    if (rd_en2) rd_data2 <= mem2[rd_addr2];
  end

  // Max-pool datapaths (unsigned maximum of the four elements).
  always_comb begin
    pmax1 = 8'h00;
    pmax2 = 8'h00;
    for (int n = 0; n < 4; n++) begin
      if (win1[n*8 +: 8] > pmax1) pmax1 = win1[n*8 +: 8];
      if (win2[n*8 +: 8] > pmax2) pmax2 = win2[n*8 +: 8];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares on every read/write strobe, away from the active edge.
  always @(negedge clk) begin
    chk("no_rd_wr_overlap1", {63'd0, rd_en1 & wr_en1}, 64'd0);
    chk("no_rd_wr_overlap2", {63'd0, rd_en2 & wr_en2}, 64'd0);
    if (rd_en1) begin
      if (rdq1.size() == 0) chk("rd1_unexpected", 64'd1, 64'd0);
      else begin
        a1 = rdq1.pop_front();
        chk("rd_addr1", 64'(rd_addr1), 64'(a1));
      end
    end
    if (wr_en1) begin
      if (sb1.size() == 0) chk("wr1_unexpected", 64'd1, 64'd0);
      else begin
        x1 = sb1.pop_front();
        chk("wr_addr1", 64'(wr_addr1), 64'(x1.addr));
        chk("wr_data1", 64'(wr_data1), 64'(x1.data));
        if (x1.chk_win) chk("win_data1", 64'(win1), 64'(x1.win));
      end
    end
    if (wr_en2) begin
      if (sb2.size() == 0) chk("wr2_unexpected", 64'd1, 64'd0);
      else begin
        x2 = sb2.pop_front();
        chk("wr_addr2", 64'(wr_addr2), 64'(x2.addr));
        chk("wr_data2", 64'(wr_data2), 64'(x2.data));
      end
    end
    if (done1) done_cnt1++;
    if (done2) done_cnt2++;
  end

  task automatic push_job1(input logic [31:0] d, input bit cw, input logic [127:0] w);
    exp_t x;
    for (int n = 0; n < 4; n++) begin
      x.addr = 8'(n);
      x.data = d[n*8 +: 8];
      x.chk_win = cw;
      x.win = w[n*32 +: 32];
      sb1.push_back(x);
    end
    for (int n = 0; n < 16; n++) rdq1.push_back(RSEQ[n]);
  endtask

  // Issue one start pulse on DUT1 and count cycles until done (bounded).
  task automatic run_job1(output int l);
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    chk("busy_cycle1", 64'(busy1), 64'd1);
    l = 1;
    while (!done1 && l < 200) begin
      @(posedge clk);
      #1 l++;
    end
    chk("busy_at_done", 64'(busy1), 64'd0);
    @(posedge clk);
    #1 chk("done_one_cycle", 64'(done1), 64'd0);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy1), 64'd0);
    chk({tag, "_done"}, 64'(done1), 64'd0);
    chk({tag, "_rd_en"}, 64'(rd_en1), 64'd0);
    chk({tag, "_wr_en"}, 64'(wr_en1), 64'd0);
    chk({tag, "_rd_addr"}, 64'(rd_addr1), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr1), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data1), 64'd0);
    chk({tag, "_win"}, 64'(win1), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int n = 0; n < 16; n++) mem1[n] = 8'(n);
    mem2 = '{8'd12, 8'd200, 8'd7,  8'd33, 8'd90,  8'd91,  8'd5,   8'd4,
             8'd3,  8'd17,  8'd250, 8'd1, 8'd0,   8'd89,  8'd6,   8'd255,
             8'd64, 8'd65,  8'd66, 8'd67, 8'd128, 8'd127, 8'd126, 8'd125,
             8'd99, 8'd1,   8'd2,  8'd3,  8'd4,   8'd5,   8'd6,   8'd100};
    repeat (3) @(posedge clk);
    #1 chk_outs_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Ramp map 0..15: first start right after reset release; read order and win layout.
    push_job1(32'h0F0D0705, 1'b1,
              {32'h0F0E0B0A, 32'h0D0C0908, 32'h07060302, 32'h05040100});
    run_job1(lat);
    chk("latency_ramp", 64'(lat), 64'd25);
    chk("sb1_empty_ramp", 64'(sb1.size()), 64'd0);
    chk("rdq1_empty_ramp", 64'(rdq1.size()), 64'd0);

    // All-FF and all-00 windows.
    mem1 = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00,
             8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    push_job1(32'h806000FF, 1'b1,
              {32'h80704030, 32'h60502010, 32'h00000000, 32'hFFFFFFFF});
    run_job1(lat);
    chk("latency_extremes", 64'(lat), 64'd25);
    chk("sb1_empty_extremes", 64'(sb1.size()), 64'd0);

    // start held for 40 cycles: two back-to-back jobs, nothing more.
    for (int n = 0; n < 16; n++) mem1[n] = 8'(n);
    push_job1(32'h0F0D0705, 1'b0, 128'd0);
    push_job1(32'h0F0D0705, 1'b0, 128'd0);
    d0 = done_cnt1;
    @(negedge clk) start1 = 1'b1;
    repeat (40) @(negedge clk);
    start1 = 1'b0;
    repeat (40) @(posedge clk);
    #1 chk("held_start_dones", 64'(done_cnt1 - d0), 64'd2);
    chk("sb1_empty_held", 64'(sb1.size()), 64'd0);
    chk("rdq1_empty_held", 64'(rdq1.size()), 64'd0);

    // Reset pulse during the second window's FETCH.
    push_job1(32'h0F0D0705, 1'b0, 128'd0);
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_outs_zero("midreset");
    chk("midreset_writes_left", 64'(sb1.size()), 64'd3);
    chk("midreset_reads_left", 64'(rdq1.size()), 64'd11);
    sb1.delete();
    rdq1.delete();
    d0 = done_cnt1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("no_done_after_abort", 64'(done_cnt1 - d0), 64'd0);
    chk("idle_after_abort", 64'(busy1), 64'd0);
    push_job1(32'h0F0D0705, 1'b1,
              {32'h0F0E0B0A, 32'h0D0C0908, 32'h07060302, 32'h05040100});
    run_job1(lat);
    chk("latency_restart", 64'(lat), 64'd25);
    chk("sb1_empty_restart", 64'(sb1.size()), 64'd0);

    // 8x4 map: eight windows in row-major order.
    begin
      logic [7:0] e2 [8];
      exp_t x;
      e2 = '{8'd200, 8'd250, 8'd91, 8'd255, 8'd99, 8'd67, 8'd128, 8'd126};
      for (int n = 0; n < 8; n++) begin
        x.addr = 8'(n);
        x.data = e2[n];
        x.chk_win = 1'b0;
        x.win = 32'd0;
        sb2.push_back(x);
      end
    end
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 300) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency_8x4", 64'(lat), 64'd49);
    repeat (2) @(posedge clk);
    #1 chk("sb2_empty", 64'(sb2.size()), 64'd0);
    chk("done2_count", 64'(done_cnt2), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
